hex_key_fifo: RTL and testbench

- Downstream consumer of the hex keypad scanner's `code` and `valid` outputs.
- Converts each detected key press into exactly one key event, suppressing contact bounce with a lockout timer.
- Buffers events in a small first-word-fall-through FIFO.
- Presents events to the host/controller logic over a valid/ready handshake, with occupancy and a sticky overflow flag.

---
 rtl/hex_key_fifo.sv | 94 +++++++++
 tb/tb_hex_key_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hex_key_fifo.sv
// hex_key_fifo: debounced key-press event FIFO (FWFT) with valid/ready output; HEX_KEY_TIMESTAMP_EN adds per-entry key_time
module hex_key_fifo #(
  parameter int DEPTH = 8,
  parameter int LOCKOUT = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    code_in,
  input  logic          valid_in,
  input  logic          clear_ovf,
  output logic [3:0]    key_code,
  output logic          key_valid,
  input  logic          key_ready,
`ifdef HEX_KEY_TIMESTAMP_EN
  output logic [15:0]   key_time,
`endif
  output logic [CW-1:0] count,
  output logic          overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LOCKOUT + 2);
  logic [LW-1:0] r_lock;
  logic          r_valid_d;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [3:0]    r_mem [DEPTH];
  logic [3:0]    r_head;
  logic          w_press, w_pop, w_full, w_push, w_drop, w_head_mem, w_head_in;
  logic [AW-1:0] w_rnext;
  assign w_press    = valid_in & ~r_valid_d & (r_lock == '0);
  assign key_valid  = r_count != '0;
  assign w_pop      = key_valid & key_ready;
  assign w_full     = r_count == CW'(DEPTH);
  assign w_push     = w_press & (~w_full | w_pop);
  assign w_drop     = w_press & w_full & ~w_pop;
  assign w_rnext    = r_rptr + AW'(1);
  // the head register reloads from the next stored entry, or straight from the input when the FIFO is (or becomes) empty
  assign w_head_mem = w_pop & (r_count > CW'(1));
  assign w_head_in  = w_push & ((r_count == '0) | (w_pop & (r_count == CW'(1))));
  assign key_code   = r_head;
  assign count      = r_count;
  assign overflow   = r_ovf;
  // press edge detect, lockout timer, pointers, occupancy and sticky overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid_d <= 1'b0;
      r_lock    <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_valid_d <= valid_in;
      r_lock    <= w_press ? LW'(LOCKOUT) : (r_lock != '0 ? r_lock - LW'(1) : r_lock);
      r_wptr    <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr    <= w_pop ? w_rnext : r_rptr;
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      r_ovf     <= w_drop | (r_ovf & ~clear_ovf);
    end
  end
  // storage array needs no reset: it is only observed through the head register
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= code_in;
  end
  // head register holds the last head value when the FIFO empties
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_head <= '0;
    else if (w_head_mem) r_head <= r_mem[w_rnext];
    else if (w_head_in) r_head <= code_in;
  end
`ifdef HEX_KEY_TIMESTAMP_EN
  logic [15:0] r_time;
  logic [15:0] r_tmem [DEPTH];
  logic [15:0] r_head_time;
  assign key_time = r_head_time;
  // free-running cycle counter and timestamped head, tracking the code head exactly
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_time      <= '0;
      r_head_time <= '0;
    end else begin
      r_time <= r_time + 16'd1;
      if (w_head_mem) r_head_time <= r_tmem[w_rnext];
      else if (w_head_in) r_head_time <= r_time;
    end
  end
  // timestamp storage alongside the code storage
  always_ff @(posedge clock) begin
    if (w_push) r_tmem[r_wptr] <= r_time;
  end
`endif
endmodule

// File: tb/tb_hex_key_fifo.sv
// tb_hex_key_fifo: directed self-checking bench for hex_key_fifo
module tb_hex_key_fifo;
  localparam int DEPTH = 8;
  localparam int LOCKOUT = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    code_in = '0;
  logic          valid_in = 1'b0;
  logic          clear_ovf = 1'b0;
  logic          key_ready = 1'b0;
  logic [3:0]    key_code;
  logic          key_valid;
  logic [CW-1:0] count;
  logic          overflow;
`ifdef HEX_KEY_TIMESTAMP_EN
  logic [15:0]   key_time;
`endif
  int errors = 0;
  int checks = 0;

  hex_key_fifo #(.DEPTH(DEPTH), .LOCKOUT(LOCKOUT)) dut (
    .clock(clock), .reset(reset), .code_in(code_in), .valid_in(valid_in),
    .clear_ovf(clear_ovf), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready),
`ifdef HEX_KEY_TIMESTAMP_EN
    .key_time(key_time),
`endif
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    code_in = c;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (LOCKOUT + 1) step();
  endtask

  task automatic pop_expect(input string tag, input logic [3:0] c);
    chk({tag, "_valid"}, 16'(key_valid), 16'd1);
    chk({tag, "_code"}, 16'(key_code), 16'(c));
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    step();
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 16'(key_valid), 16'd0);
    chk("rst_code", 16'(key_code), 16'd0);
    chk("rst_count", 16'(count), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);

    code_in = 4'h5;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("single_valid", 16'(key_valid), 16'd1);
    chk("single_code", 16'(key_code), 16'h5);
    chk("single_count", 16'(count), 16'd1);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    chk("single_pop_valid", 16'(key_valid), 16'd0);
    chk("single_pop_count", 16'(count), 16'd0);
    chk("single_hold_code", 16'(key_code), 16'h5);
    repeat (LOCKOUT + 2) step();

    for (int c = 0; c <= 20; c++) begin
      valid_in = (c == 0 || c == 3 || c == 9 || c == 20);
      code_in = (c == 20) ? 4'hB : 4'hA;
      step();
    end
    valid_in = 1'b0;
    chk("bounce_count", 16'(count), 16'd2);
    chk("bounce_ovf", 16'(overflow), 16'd0);
    pop_expect("bounce0", 4'hA);
    pop_expect("bounce1", 4'hB);
    chk("bounce_empty", 16'(count), 16'd0);
    repeat (LOCKOUT + 2) step();

    for (int i = 0; i < 9; i++) press(4'(i));
    chk("ovf_count", 16'(count), 16'd8);
    chk("ovf_flag", 16'(overflow), 16'd1);
    for (int i = 0; i < 8; i++) pop_expect($sformatf("ovf_drain%0d", i), 4'(i));
    chk("ovf_drained", 16'(count), 16'd0);
    chk("ovf_sticky", 16'(overflow), 16'd1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("ovf_cleared", 16'(overflow), 16'd0);

    for (int i = 0; i < 8; i++) press(4'(i));
    chk("full_count", 16'(count), 16'd8);
    code_in = 4'hC;
    valid_in = 1'b1;
    key_ready = 1'b1;
    step();
    valid_in = 1'b0;
    key_ready = 1'b0;
    chk("fullpop_count", 16'(count), 16'd8);
    chk("fullpop_ovf", 16'(overflow), 16'd0);
    for (int i = 1; i < 8; i++) pop_expect($sformatf("fullpop_drain%0d", i), 4'(i));
    pop_expect("fullpop_last", 4'hC);
    chk("fullpop_empty", 16'(key_valid), 16'd0);
    repeat (LOCKOUT + 2) step();

    press(4'h1);
    press(4'h2);
    code_in = 4'h3;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    chk("pre_rst_count", 16'(count), 16'd3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 16'(key_valid), 16'd0);
    chk("async_rst_count", 16'(count), 16'd0);
    #1 reset = 1'b0;
    step();
    code_in = 4'hF;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("post_rst_valid", 16'(key_valid), 16'd1);
    chk("post_rst_code", 16'(key_code), 16'hF);
    chk("post_rst_count", 16'(count), 16'd1);

`ifdef HEX_KEY_TIMESTAMP_EN
    do_reset();
    repeat (99) step();
    code_in = 4'h3;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (39) step();
    code_in = 4'h4;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("ts0_time", key_time, 16'd100);
    pop_expect("ts0", 4'h3);
    chk("ts1_time", key_time, 16'd140);
    pop_expect("ts1", 4'h4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
